// File: rtl/mfrc522_spi_responder.sv
// mfrc522_spi_responder
//   SPI mode-0 slave that behaves like the MFRC522 register interface. It
//   serves reads and writes from a 64x8 register file. SPI writes are reported
//   to a host, and the host can stage register contents through its own write
//   port.
//
// Ports
//   i_clk, i_rst        fabric clock, synchronous active-high reset
//   i_spi_sclk          SPI clock from the master (idle low)
//   i_spi_cs_n          chip select, active low
//   i_spi_mosi          master-out data, sampled on the sclk rise
//   o_spi_miso          slave-out data, MSB first, shifted on the sclk fall
//   i_host_wr_en/addr/data   host register write; an SPI commit in the same cycle wins
//   o_reg_wr_evt        one-cycle pulse after an SPI write commit
//   o_reg_wr_addr/data  address and data of the last SPI commit (held)
//   o_xfer_active       high while a frame is in progress
//   o_frame_err         one-cycle pulse on an address byte with bit0 set
module mfrc522_spi_responder #(
  parameter int unsigned CLK_HZ      = 32_000_000,
  parameter int unsigned SPI_HZ      = 4_000_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  VERSION     = 8'h92
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_sclk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  input  logic       i_host_wr_en,
  input  logic [5:0] i_host_wr_addr,
  input  logic [7:0] i_host_wr_data,
  output logic       o_reg_wr_evt,
  output logic [5:0] o_reg_wr_addr,
  output logic [7:0] o_reg_wr_data,
  output logic       o_xfer_active,
  output logic       o_frame_err
);

  localparam bit CFG_OK = (CLK_HZ >= 8 * SPI_HZ) && (SYNC_STAGES >= 2);

  if (!CFG_OK) begin : g_cfg_check
    $error("mfrc522_spi_responder: need CLK_HZ >= 8*SPI_HZ and SYNC_STAGES >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_IGNORE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic       r_sclk_prev, r_cs_prev;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [5:0] r_addr;
  logic [7:0] r_regs [64];
  logic       r_wr_evt, r_ferr;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic       w_sclk, w_cs_n, w_mosi;
  logic       w_sclk_rise, w_sclk_fall, w_cs_fall;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic [5:0] w_new_addr;
  logic       w_start, w_load, w_latch, w_commit, w_err;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  // The cs history resets low, so a cs_n held low across reset is not seen
  // as a fall. It must go high and then low again.
  assign w_cs_fall   = ~w_cs_n & r_cs_prev;

  assign w_rx_byte   = {r_rx, w_mosi};
  assign w_new_addr  = w_rx_byte[6:1];
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && !w_cs_n;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: if (w_cs_fall) begin
        w_state_nxt = S_ADDR;
        w_start     = 1'b1;
      end
      S_ADDR: if (w_byte_done) begin
        if (w_rx_byte[0]) begin
          w_err       = 1'b1;
          w_state_nxt = S_IGNORE;
        end else begin
          w_latch = 1'b1;
          if (w_rx_byte[7]) begin
            w_load      = 1'b1;
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      // In a read, each MOSI byte is the next address. Its RW bit is ignored.
      S_READ: if (w_byte_done) begin
        if (w_rx_byte[0]) begin
          w_err       = 1'b1;
          w_state_nxt = S_IGNORE;
        end else begin
          w_latch = 1'b1;
          w_load  = 1'b1;
        end
      end
      S_WRITE:  if (w_byte_done) w_commit = 1'b1;
      S_IGNORE: ;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A cs_n that goes high ends the frame from any state. A partial byte is dropped.
    if (w_cs_n) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_addr      <= 6'd0;
      r_wr_evt    <= 1'b0;
      r_ferr      <= 1'b0;
      r_wr_addr   <= 6'd0;
      r_wr_data   <= 8'd0;
      for (int i = 0; i < 64; i++)
        r_regs[i] <= (i == 'h37) ? VERSION : 8'h00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
      r_state     <= w_state_nxt;
      r_wr_evt    <= 1'b0;
      r_ferr      <= w_err;

      if (w_start) begin
        r_bit_cnt <= 3'd0;
        r_rx      <= 7'd0;
      end else if (w_sclk_rise && r_state != S_IDLE) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_rx_byte[6:0];
      end

      if (w_latch) r_addr <= w_new_addr;

      // MISO carries data only in READ. The fall right after the 8th rise
      // leaves the new byte's MSB on the line (bit count has wrapped to 0).
      if (w_state_nxt != S_READ)
        r_tx <= 8'd0;
      else if (w_load)
        r_tx <= r_regs[w_new_addr];
      else if (w_sclk_fall && r_bit_cnt != 3'd0)
        r_tx <= {r_tx[6:0], 1'b0};

      if (w_commit) begin
        r_regs[r_addr] <= w_rx_byte;
        r_wr_evt       <= 1'b1;
        r_wr_addr      <= r_addr;
        r_wr_data      <= w_rx_byte;
      end else if (i_host_wr_en) begin
        r_regs[i_host_wr_addr] <= i_host_wr_data;
      end
    end
  end

  assign o_spi_miso    = r_tx[7];
  assign o_reg_wr_evt  = r_wr_evt;
  assign o_reg_wr_addr = r_wr_addr;
  assign o_reg_wr_data = r_wr_data;
  assign o_xfer_active = (r_state != S_IDLE);
  assign o_frame_err   = r_ferr;

endmodule

// File: tb/tb_mfrc522_spi_responder.sv
`timescale 1ns/1ps
module tb_mfrc522_spi_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso;
  logic       host_wr_en = 1'b0;
  logic [5:0] host_wr_addr = 6'd0;
  logic [7:0] host_wr_data = 8'd0;
  logic       wr_evt, xact, ferr;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_ferr = 0;
  logic [13:0] evq[$];
  logic [7:0] r0, r1, r2;

  always #5 clk = ~clk;

  mfrc522_spi_responder dut (
    .i_clk(clk), .i_rst(rst),
    .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi), .o_spi_miso(miso),
    .i_host_wr_en(host_wr_en), .i_host_wr_addr(host_wr_addr), .i_host_wr_data(host_wr_data),
    .o_reg_wr_evt(wr_evt), .o_reg_wr_addr(wr_addr), .o_reg_wr_data(wr_data),
    .o_xfer_active(xact), .o_frame_err(ferr)
  );

  // Event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_evt) evq.push_back({wr_addr, wr_data});
      if (ferr) n_ferr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One byte, master mode 0: MOSI is set while sclk is low. MISO is captured just before the rise.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit coll, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      if (coll && i == 7) begin
        // The synced rise is seen two clocks later. Strobe the host write into the commit cycle.
        @(negedge clk); @(negedge clk);
        host_wr_en = 1'b1;
        @(negedge clk);
        host_wr_en = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
    host_wr_addr = a; host_wr_data = d; host_wr_en = 1'b1;
    @(negedge clk);
    host_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_read1(input logic [7:0] abyte, output logic [7:0] d);
    logic [7:0] dummy;
    cs_begin();
    spi_byte(abyte, 8, 1'b0, dummy);
    spi_byte(8'h00, 8, 1'b0, d);
    cs_end();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_evt", wr_evt, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_xact", xact, 0);
    chk("rst_ferr", ferr, 0);
    repeat (4) @(negedge clk);

    // VersionReg read. xfer_active follows cs_n.
    cs_begin();
    chk("ver_xact_in", xact, 1);
    spi_byte(8'hEE, 8, 1'b0, r0);
    spi_byte(8'h00, 8, 1'b0, r1);
    chk("ver_b0", r0, 8'h00);
    chk("ver_b1", r1, 8'h92);
    cs_end();
    chk("ver_xact_out", xact, 0);

    // Host stages 0x5A at 0x04, then SPI reads it
    evq.delete();
    host_wr(6'h04, 8'h5A);
    cs_begin();
    spi_byte(8'h88, 8, 1'b0, r0);
    spi_byte(8'h00, 8, 1'b0, r1);
    cs_end();
    chk("rd04_b0", r0, 8'h00);
    chk("rd04_b1", r1, 8'h5A);
    chk("rd04_noevt", evq.size(), 0);

    // Repeated write to 0x01
    evq.delete();
    cs_begin();
    spi_byte(8'h02, 8, 1'b0, r0);
    spi_byte(8'h11, 8, 1'b0, r1);
    spi_byte(8'h22, 8, 1'b0, r2);
    cs_end();
    chk("wr_miso", {r0, r1, r2}, 24'h0);
    chk("wr_nevt", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("wr_evt0", evq[0], {6'h01, 8'h11});
      chk("wr_evt1", evq[1], {6'h01, 8'h22});
    end
    chk("wr_hold", {wr_addr, wr_data}, {6'h01, 8'h22});
    spi_read1(8'h82, r1);
    chk("wr_readback", r1, 8'h22);

    // Burst read
    host_wr(6'h01, 8'hA1);
    host_wr(6'h02, 8'hB2);
    cs_begin();
    spi_byte(8'h82, 8, 1'b0, r0);
    spi_byte(8'h84, 8, 1'b0, r1);
    spi_byte(8'h00, 8, 1'b0, r2);
    cs_end();
    chk("burst", {r0, r1, r2}, 24'h00A1B2);

    // Malformed address byte
    evq.delete();
    n_ferr = 0;
    cs_begin();
    spi_byte(8'h03, 8, 1'b0, r0);
    spi_byte(8'h82, 8, 1'b0, r1);
    spi_byte(8'h00, 8, 1'b0, r2);
    cs_end();
    chk("ferr_cnt", n_ferr, 1);
    chk("ferr_miso", {r0, r1, r2}, 24'h0);
    chk("ferr_noevt", evq.size(), 0);

    // Partial data byte is discarded
    cs_begin();
    spi_byte(8'h02, 8, 1'b0, r0);
    spi_byte(8'hF0, 4, 1'b0, r1);
    cs_end();
    chk("partial_noevt", evq.size(), 0);
    spi_read1(8'h82, r1);
    chk("partial_reg", r1, 8'hA1);

    // Host write collides with an SPI commit to 0x10
    evq.delete();
    host_wr_addr = 6'h10; host_wr_data = 8'h77;
    cs_begin();
    spi_byte(8'h20, 8, 1'b0, r0);
    spi_byte(8'h33, 8, 1'b1, r1);
    cs_end();
    chk("coll_nevt", evq.size(), 1);
    if (evq.size() == 1) chk("coll_evt", evq[0], {6'h10, 8'h33});
    spi_read1(8'hA0, r1);
    chk("coll_reg", r1, 8'h33);

    // Reset mid-frame with cs_n held low: the block stays idle until cs_n toggles
    evq.delete();
    n_ferr = 0;
    cs_begin();
    spi_byte(8'h02, 3, 1'b0, r0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_xact0", xact, 0);
    spi_byte(8'h02, 8, 1'b0, r0);
    spi_byte(8'h55, 8, 1'b0, r1);
    chk("mrst_xact1", xact, 0);
    cs_end();
    chk("mrst_noevt", evq.size(), 0);
    chk("mrst_noferr", n_ferr, 0);
    spi_read1(8'h82, r1);
    chk("mrst_reg01", r1, 8'h00);
    spi_read1(8'hEE, r1);
    chk("mrst_ver", r1, 8'h92);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mfrc522_spi_responder.md
Name: mfrc522_spi_responder

Overview:
SPI mode-0 slave that emulates the MFRC522 register interface on the shared SPI bus.
- Lets the NFC detector and shared SPI master run against an in-fabric device model in bench and on hardware loopback.
- Decodes MFRC522 address framing and serves reads and writes from a 64x8 register file.
- Reports SPI-side writes to a host, and accepts host-side writes so a testbench or model can stage responses.

Parameters:
CLK_HZ, 32_000_000, fabric clock frequency; must be at least 8x the SPI clock.
SPI_HZ, 4_000_000, maximum SPI clock supported (documentation and assertion only).
SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2).
VERSION, 8'h92, reset value of register 0x37 (VersionReg).

Ports:
clk  in  1  fabric clock
rst  in  1  synchronous active-high reset
spi_sclk  in  1  SPI clock from master, idle low
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
host_wr_en  in  1  host register write strobe
host_wr_addr  in  6  host write address
host_wr_data  in  8  host write data
reg_wr_evt  out  1  one-cycle pulse: an SPI write was committed
reg_wr_addr  out  6  address of the committed SPI write
reg_wr_data  out  8  data of the committed SPI write
xfer_active  out  1  high while a frame is in progress
frame_err  out  1  one-cycle pulse on a malformed address byte

Behaviour:
Reset
- Clock is clk only; reset is synchronous, active-high.
- Outputs after reset: spi_miso=0, reg_wr_evt=0, reg_wr_addr=0, reg_wr_data=0, xfer_active=0, frame_err=0.
- Register file clears to 0x00, except reg[0x37]=VERSION.
- If cs_n is low when rst deasserts, the block stays IDLE until cs_n has been seen high and then falls again.

Input synchronisation and edges
- Inputs pass through SYNC_STAGES flops.
- Rise, fall and cs-fall are detected on the synced values.
- MOSI is sampled on synced sclk rise.
- MISO shifts on synced sclk fall; MSB first.

Address byte format
- {RW, addr[5:0], 0}. RW=1 means read.

State machine: IDLE, ADDR, READ, WRITE, IGNORE
- IDLE:
  - cs fall -> ADDR, xfer_active=1, bit count=0, MISO shift register=0x00.
- ADDR (byte 0):
  - MISO returns 0x00.
  - After the 8th rise: if bit0=1, pulse frame_err and go to IGNORE.
  - Otherwise latch addr; RW=1 -> READ, load the shift register with reg[addr] in the same cycle; RW=0 -> WRITE.
- READ (bytes 1..n):
  - MISO shifts the loaded data.
  - The MOSI byte is the next address byte. At its 8th rise, decode it the same way as the ADDR byte; bit0=1 pulses frame_err and goes to IGNORE.
  - Otherwise reload the shift register with reg[new addr]; the RW bit of follow-on bytes is ignored.
  - The trailing 0x00 byte sent by the master reloads reg[0x00]; this is harmless.
- WRITE (bytes 1..n):
  - MISO returns 0x00.
  - Each completed byte writes reg[addr] at the 8th rise; the address does not increment (FIFO-style repeat).
  - The cycle after a write: reg_wr_evt=1, with reg_wr_addr/reg_wr_data holding addr/byte; these hold until the next event.
- IGNORE: MISO=0, no writes until cs rise.

Frame termination
- cs rise in any state -> IDLE, xfer_active=0, spi_miso=0.
- A partial byte is discarded: no write, no error.

Host write port
- Writes reg[host_wr_addr] in the cycle host_wr_en is high.
- If it collides in the same cycle with an SPI write commit to any address, the SPI write wins and the host write is dropped.
- A host write to an address already loaded into the MISO shift register does not alter the byte in flight.

Latency and timing
- Bit timing: MISO changes 1+SYNC_STAGES clk after the sclk fall.
- At CLK_HZ/SPI_HZ >= 8, this meets master setup at the next rise.

Test Plan:
- Host writes 0x5A to 0x04; SPI frame 0x88,0x00 (read 0x04) -> MISO bytes 0x00,0x5A; no reg_wr_evt.
- Reset, then SPI read 0xEE,0x00 (read 0x37) -> MISO second byte 0x92; xfer_active high exactly while cs_n low.
- SPI write 0x02,0x11,0x22 (addr 0x01) -> two reg_wr_evt pulses with (0x01,0x11) then (0x01,0x22); subsequent read of 0x01 returns 0x22.
- Burst read 0x82,0x84,0x00 with reg[0x01]=0xA1, reg[0x02]=0xB2 -> MISO 0x00,0xA1,0xB2.
- Address byte 0x03 -> frame_err single pulse, MISO 0x00 for rest of frame, no writes; cs_n raised after 4 bits of a write data byte -> no reg_wr_evt.
- host_wr_en to 0x10 in the same cycle as an SPI commit to 0x10 (data 0x33) -> reg[0x10]=0x33; rst asserted mid-frame with cs_n held low -> no activity until cs_n toggles high then low.
